// File: rtl/beep_seq.sv
// Programmable beeper: plays count ON phases of tone A, separated by OFF phases
// that are either silent (mode=0) or tone B (mode=1), then signals completion.
module beep_seq #(
  parameter int unsigned MS_DIV = 1000,
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned DUR_W  = 10,
  parameter int unsigned CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [DIV_W-1:0] half_a,
  input  logic [DIV_W-1:0] half_b,
  input  logic [DUR_W-1:0] on_ms,
  input  logic [DUR_W-1:0] off_ms,
  input  logic [CNT_W-1:0] count,
  output logic             beep,
  output logic             busy,
  output logic             done,
  output logic             over
);

  localparam int unsigned TICK_W = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(MS_DIV - 1);

  typedef enum logic [1:0] {IDLE, ON, OFF, DONE} state_t;

  state_t             state_q, state_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [DUR_W-1:0]   ms_q, ms_d;
  logic [DIV_W-1:0]   tone_q, tone_d;
  logic [CNT_W-1:0]   left_q, left_d;
  logic               mode_q, mode_d;
  logic [DIV_W-1:0]   ha_q, ha_d, hb_q, hb_d;
  logic [DUR_W-1:0]   on_q, on_d, off_q, off_d;
  logic               beep_d, busy_d, done_d, over_d;

  logic [DUR_W-1:0]   phase_len;
  logic [DIV_W-1:0]   half;
  logic               tone_en;
  logic               phase_end;

  // Zero lengths and half-periods behave as 1
  always_comb begin
    phase_len = (state_q == ON) ? ((on_q == '0) ? DUR_W'(1) : on_q)
                                : ((off_q == '0) ? DUR_W'(1) : off_q);
    half      = (state_q == ON) ? ((ha_q == '0) ? DIV_W'(1) : ha_q)
                                : ((hb_q == '0) ? DIV_W'(1) : hb_q);
    tone_en   = (state_q == ON) || ((state_q == OFF) && mode_q);
    phase_end = (ms_q == phase_len - DUR_W'(1)) && (tick_q == TICK_LAST);
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    ms_d    = ms_q;
    tone_d  = tone_q;
    left_d  = left_q;
    mode_d  = mode_q;
    ha_d    = ha_q;
    hb_d    = hb_q;
    on_d    = on_q;
    off_d   = off_q;
    beep_d  = beep;
    busy_d  = busy;
    done_d  = 1'b0;
    over_d  = over;

    case (state_q)
      IDLE, DONE: begin
        tick_d = '0;
        ms_d   = '0;
        tone_d = '0;
        beep_d = 1'b0;
        if (start) begin
          mode_d = mode;
          ha_d   = half_a;
          hb_d   = half_b;
          on_d   = on_ms;
          off_d  = off_ms;
          left_d = count;
          if (count == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            over_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = ON;
            over_d  = 1'b0;
            busy_d  = 1'b1;
          end
        end
      end
      ON, OFF: begin
        if (phase_end) begin
          tick_d = '0;
          ms_d   = '0;
          tone_d = '0;
          beep_d = 1'b0;
          if (state_q == OFF) begin
            state_d = ON;
          end else if (left_q == CNT_W'(1)) begin
            state_d = DONE;
            done_d  = 1'b1;
            over_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = OFF;
            left_d  = left_q - CNT_W'(1);
          end
        end else begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            ms_d   = ms_q + DUR_W'(1);
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
          // Tone counter runs every cycle; only the output toggle is gated
          if (tone_q == half - DIV_W'(1)) begin
            tone_d = '0;
            beep_d = tone_en ? ~beep : 1'b0;
          end else begin
            tone_d = tone_q + DIV_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      ms_q    <= '0;
      tone_q  <= '0;
      left_q  <= '0;
      mode_q  <= 1'b0;
      ha_q    <= '0;
      hb_q    <= '0;
      on_q    <= '0;
      off_q   <= '0;
      beep    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      over    <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      ms_q    <= ms_d;
      tone_q  <= tone_d;
      left_q  <= left_d;
      mode_q  <= mode_d;
      ha_q    <= ha_d;
      hb_q    <= hb_d;
      on_q    <= on_d;
      off_q   <= off_d;
      beep    <= beep_d;
      busy    <= busy_d;
      done    <= done_d;
      over    <= over_d;
    end
  end

endmodule
